// File: rtl/mem_burst_arbiter_if.sv
// Burst port bundle shared by both masters and the SDRAM controller.
// master: request/len/addr/wdata out; slave: strobes and read data out.
interface mem_burst_arbiter_if #(
  parameter int MEM_DATA_BITS = 16,
  parameter int ADDR_BITS     = 24,
  parameter int BUSRT_BITS    = 10
);
  logic                     rd_burst_req;
  logic                     wr_burst_req;
  logic [BUSRT_BITS-1:0]    rd_burst_len;
  logic [BUSRT_BITS-1:0]    wr_burst_len;
  logic [ADDR_BITS-1:0]     rd_burst_addr;
  logic [ADDR_BITS-1:0]     wr_burst_addr;
  logic [MEM_DATA_BITS-1:0] wr_burst_data;
  logic                     wr_burst_data_req;
  logic                     rd_burst_data_valid;
  logic                     rd_burst_finish;
  logic                     wr_burst_finish;
  logic [MEM_DATA_BITS-1:0] rd_burst_data;

  modport master (
    output rd_burst_req, wr_burst_req,
    output rd_burst_len, wr_burst_len,
    output rd_burst_addr, wr_burst_addr,
    output wr_burst_data,
    input  wr_burst_data_req, rd_burst_data_valid,
    input  rd_burst_finish, wr_burst_finish,
    input  rd_burst_data
  );

  modport slave (
    input  rd_burst_req, wr_burst_req,
    input  rd_burst_len, wr_burst_len,
    input  rd_burst_addr, wr_burst_addr,
    input  wr_burst_data,
    output wr_burst_data_req, rd_burst_data_valid,
    output rd_burst_finish, wr_burst_finish,
    output rd_burst_data
  );
endinterface

// File: rtl/mem_burst_arbiter.sv
// Two-master burst arbiter in front of one SDRAM controller.
// Ports: clk, rst (async, active-high); m0/m1 (slave side of the
// burst bundle); ctl (master side toward controller); grant_id
// = {valid, master}. Define ARB_FIXED_PRIO_EN for fixed m0 priority
// instead of round-robin.
module mem_burst_arbiter #(
  parameter int MEM_DATA_BITS = 16,
  parameter int ADDR_BITS     = 24,
  parameter int BUSRT_BITS    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_burst_arbiter_if.slave   m0,
  mem_burst_arbiter_if.slave   m1,
  mem_burst_arbiter_if.master  ctl,
  output logic [1:0]           grant_id
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  gnt_v_q, gnt_v_d;
  logic                  gnt_m_q, gnt_m_d;
  logic                  dir_q, dir_d;
  logic                  zero_q, zero_d;
  logic                  rd_req_q, rd_req_d;
  logic                  wr_req_q, wr_req_d;
  logic [BUSRT_BITS-1:0] len_q, len_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
`ifndef ARB_FIXED_PRIO_EN
  logic                  last_q, last_d;
`endif

  logic                  m0_any, m1_any;
  logic                  sel, sel_wr;
  logic [BUSRT_BITS-1:0] sel_len;
  logic [ADDR_BITS-1:0]  sel_addr;
  logic                  g0, g1;

  // Pick a master, then write over read within it.
  always_comb begin
    m0_any = m0.rd_burst_req | m0.wr_burst_req;
    m1_any = m1.rd_burst_req | m1.wr_burst_req;
`ifdef ARB_FIXED_PRIO_EN
    sel = ~m0_any;
`else
    // last_q=1: m1 served last, so m0 has the turn
    sel = last_q ? ~m0_any : m1_any;
`endif
    sel_wr = sel ? m1.wr_burst_req : m0.wr_burst_req;
    if (sel) begin
      sel_len  = sel_wr ? m1.wr_burst_len : m1.rd_burst_len;
      sel_addr = sel_wr ? m1.wr_burst_addr : m1.rd_burst_addr;
    end else begin
      sel_len  = sel_wr ? m0.wr_burst_len : m0.rd_burst_len;
      sel_addr = sel_wr ? m0.wr_burst_addr : m0.rd_burst_addr;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_v_d  = gnt_v_q;
    gnt_m_d  = gnt_m_q;
    dir_d    = dir_q;
    zero_d   = zero_q;
    rd_req_d = rd_req_q;
    wr_req_d = wr_req_q;
    len_d    = len_q;
    addr_d   = addr_q;
`ifndef ARB_FIXED_PRIO_EN
    last_d   = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (m0_any | m1_any) begin
          gnt_v_d = 1'b1;
          gnt_m_d = sel;
          dir_d   = sel_wr;
          len_d   = sel_len;
          addr_d  = sel_addr;
`ifndef ARB_FIXED_PRIO_EN
          last_d  = sel;
`endif
          if (sel_len == '0) begin
            // empty burst: finish locally, never bother ctl
            zero_d  = 1'b1;
            state_d = DONE;
          end else if (sel_wr) begin
            wr_req_d = 1'b1;
            state_d  = WR;
          end else begin
            rd_req_d = 1'b1;
            state_d  = RD;
          end
        end
      end
      RD: begin
        if (ctl.rd_burst_finish) begin
          rd_req_d = 1'b0;
          state_d  = DONE;
        end
      end
      WR: begin
        if (ctl.wr_burst_finish) begin
          wr_req_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        zero_d  = 1'b0;
        gnt_v_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_v_q  <= 1'b0;
      gnt_m_q  <= 1'b0;
      dir_q    <= 1'b0;
      zero_q   <= 1'b0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      len_q    <= '0;
      addr_q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      gnt_v_q  <= gnt_v_d;
      gnt_m_q  <= gnt_m_d;
      dir_q    <= dir_d;
      zero_q   <= zero_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
`ifndef ARB_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end

  assign g0 = gnt_v_q & ~gnt_m_q;
  assign g1 = gnt_v_q & gnt_m_q;

  assign ctl.rd_burst_req  = rd_req_q;
  assign ctl.wr_burst_req  = wr_req_q;
  assign ctl.rd_burst_len  = len_q;
  assign ctl.wr_burst_len  = len_q;
  assign ctl.rd_burst_addr = addr_q;
  assign ctl.wr_burst_addr = addr_q;
  assign ctl.wr_burst_data = g1 ? m1.wr_burst_data :
                             g0 ? m0.wr_burst_data : '0;

  assign m0.wr_burst_data_req   = g0 & ctl.wr_burst_data_req;
  assign m0.rd_burst_data_valid = g0 & ctl.rd_burst_data_valid;
  assign m0.rd_burst_finish     = g0 & (ctl.rd_burst_finish |
                                        (zero_q & ~dir_q));
  assign m0.wr_burst_finish     = g0 & (ctl.wr_burst_finish |
                                        (zero_q & dir_q));
  assign m0.rd_burst_data       = ctl.rd_burst_data;

  assign m1.wr_burst_data_req   = g1 & ctl.wr_burst_data_req;
  assign m1.rd_burst_data_valid = g1 & ctl.rd_burst_data_valid;
  assign m1.rd_burst_finish     = g1 & (ctl.rd_burst_finish |
                                        (zero_q & ~dir_q));
  assign m1.wr_burst_finish     = g1 & (ctl.wr_burst_finish |
                                        (zero_q & dir_q));
  assign m1.rd_burst_data       = ctl.rd_burst_data;

  assign grant_id = {gnt_v_q, gnt_m_q};
endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Randomised scoreboard bench for mem_burst_arbiter.
// Masters queue expected bursts; a monitor checks grants and data.
module tb_mem_burst_arbiter;
  localparam int DW = 16;
  localparam int AW = 24;
  localparam int LW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_burst_arbiter_if #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW),
    .BUSRT_BITS(LW)) m0_if ();
  mem_burst_arbiter_if #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW),
    .BUSRT_BITS(LW)) m1_if ();
  mem_burst_arbiter_if #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW),
    .BUSRT_BITS(LW)) ctl_if ();
  logic [1:0] grant_id;

  mem_burst_arbiter #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW),
    .BUSRT_BITS(LW)) dut (
    .clk(clk), .rst(rst),
    .m0(m0_if), .m1(m1_if), .ctl(ctl_if),
    .grant_id(grant_id)
  );

  typedef struct {
    bit            wr;
    int            len;
    logic [AW-1:0] addr;
    longint        stamp;
  } burst_t;

  burst_t exp_q[2][$];
  int n_chk = 0;
  int n_pass = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a,
                                        input int i);
    logic [DW-1:0] r;
    r = a[DW-1:0] ^ (DW'(i) * 16'h0107) ^ DW'(a[AW-1:DW]);
    return r;
  endfunction

  function automatic logic [DW-1:0] rpat(input logic [AW-1:0] a,
                                         input int i);
    return ~pat(a, i);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // master-side drive
  logic          rq_rd[2];
  logic          rq_wr[2];
  logic [LW-1:0] rlen[2];
  logic [LW-1:0] wlen[2];
  logic [AW-1:0] raddr[2];
  logic [AW-1:0] waddr[2];
  int rcnt[2] = '{0, 0};
  int wcnt[2] = '{0, 0};
  int rbase[2] = '{0, 0};
  int wbase[2] = '{0, 0};

  assign m0_if.rd_burst_req  = rq_rd[0];
  assign m0_if.wr_burst_req  = rq_wr[0];
  assign m0_if.rd_burst_len  = rlen[0];
  assign m0_if.wr_burst_len  = wlen[0];
  assign m0_if.rd_burst_addr = raddr[0];
  assign m0_if.wr_burst_addr = waddr[0];
  assign m0_if.wr_burst_data = pat(waddr[0], wcnt[0] - wbase[0]);
  assign m1_if.rd_burst_req  = rq_rd[1];
  assign m1_if.wr_burst_req  = rq_wr[1];
  assign m1_if.rd_burst_len  = rlen[1];
  assign m1_if.wr_burst_len  = wlen[1];
  assign m1_if.rd_burst_addr = raddr[1];
  assign m1_if.wr_burst_addr = waddr[1];
  assign m1_if.wr_burst_data = pat(waddr[1], wcnt[1] - wbase[1]);

  logic          o_wdreq[2];
  logic          o_rvalid[2];
  logic          o_rfin[2];
  logic          o_wfin[2];
  logic [DW-1:0] o_rdata[2];
  assign o_wdreq[0]  = m0_if.wr_burst_data_req;
  assign o_rvalid[0] = m0_if.rd_burst_data_valid;
  assign o_rfin[0]   = m0_if.rd_burst_finish;
  assign o_wfin[0]   = m0_if.wr_burst_finish;
  assign o_rdata[0]  = m0_if.rd_burst_data;
  assign o_wdreq[1]  = m1_if.wr_burst_data_req;
  assign o_rvalid[1] = m1_if.rd_burst_data_valid;
  assign o_rfin[1]   = m1_if.rd_burst_finish;
  assign o_wfin[1]   = m1_if.wr_burst_finish;
  assign o_rdata[1]  = m1_if.rd_burst_data;

  // master read-data check and write-word counting
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (o_rvalid[m]) begin
        chk($sformatf("m%0d_rd_data", m), 64'(o_rdata[m]),
            64'(rpat(raddr[m], rcnt[m] - rbase[m])));
        rcnt[m]++;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    for (int m = 0; m < 2; m++)
      if (o_wdreq[m]) wcnt[m]++;
  end

  // controller model
  int            c_st = 0;
  int            c_len = 0;
  int            c_idx = 0;
  bit            c_wr = 1'b0;
  logic [AW-1:0] c_addr = '0;

  initial begin
    ctl_if.wr_burst_data_req   = 1'b0;
    ctl_if.rd_burst_data_valid = 1'b0;
    ctl_if.rd_burst_finish     = 1'b0;
    ctl_if.wr_burst_finish     = 1'b0;
    ctl_if.rd_burst_data       = '0;
    forever begin
      @(posedge clk);
      #1;
      ctl_if.wr_burst_data_req   = 1'b0;
      ctl_if.rd_burst_data_valid = 1'b0;
      ctl_if.rd_burst_finish     = 1'b0;
      ctl_if.wr_burst_finish     = 1'b0;
      if (rst) c_st = 0;
      else if (c_st == 0) begin
        if (ctl_if.wr_burst_req || ctl_if.rd_burst_req) begin
          c_wr   = ctl_if.wr_burst_req;
          c_len  = c_wr ? int'(ctl_if.wr_burst_len)
                        : int'(ctl_if.rd_burst_len);
          c_addr = c_wr ? ctl_if.wr_burst_addr
                        : ctl_if.rd_burst_addr;
          c_idx  = -1;
          c_st   = 1;
        end
      end else if (c_st == 1) begin
        if (c_idx + 1 >= c_len) begin
          if (c_wr) ctl_if.wr_burst_finish = 1'b1;
          else      ctl_if.rd_burst_finish = 1'b1;
          c_st = 2;
        end else if ($urandom_range(0, 3) != 0) begin
          c_idx++;
          if (c_wr) ctl_if.wr_burst_data_req = 1'b1;
          else begin
            ctl_if.rd_burst_data_valid = 1'b1;
            ctl_if.rd_burst_data = rpat(c_addr, c_idx);
          end
        end
      end else if (!ctl_if.wr_burst_req && !ctl_if.rd_burst_req) begin
        c_st = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (ctl_if.wr_burst_data_req)
      chk("ctl_wr_data", 64'(ctl_if.wr_burst_data),
          64'(pat(c_addr, c_idx)));
  end

  // grant monitor with reference arbitration model
  bit pv = 1'b0;
  bit last_srv = 1'b1;
  int cur_m = 0;

  always @(negedge clk) begin
    bit r0, r1;
    int w;
    burst_t e;
    if (rst) begin
      pv = 1'b0;
      last_srv = 1'b1;
    end else begin
      if (grant_id[1] && !pv) begin
        r0 = exp_q[0].size() > 0 && exp_q[0][0].stamp < cyc;
        r1 = exp_q[1].size() > 0 && exp_q[1][0].stamp < cyc;
        if (!r0 && !r1) begin
          n_chk++;
          $display("FAIL spurious_grant: got %0b required none at %0t",
                   grant_id, $time);
        end else begin
`ifdef ARB_FIXED_PRIO_EN
          w = r0 ? 0 : 1;
`else
          w = last_srv ? (r0 ? 0 : 1) : (r1 ? 1 : 0);
`endif
          last_srv = (w == 1);
          cur_m = w;
          chk("grant_id", 64'(grant_id), 64'({1'b1, w[0]}));
          e = exp_q[w].pop_front();
          if (e.len == 0) begin
            chk("zero_len_no_req",
                64'({ctl_if.wr_burst_req, ctl_if.rd_burst_req}), 64'(0));
            chk("zero_len_fin", 64'({o_wfin[w], o_rfin[w]}),
                64'({e.wr, !e.wr}));
          end else begin
            chk("ctl_req",
                64'({ctl_if.wr_burst_req, ctl_if.rd_burst_req}),
                64'({e.wr, !e.wr}));
            chk("ctl_len", 64'(e.wr ? ctl_if.wr_burst_len
                                    : ctl_if.rd_burst_len),
                64'(e.len));
            chk("ctl_addr", 64'(e.wr ? ctl_if.wr_burst_addr
                                     : ctl_if.rd_burst_addr),
                64'(e.addr));
          end
        end
      end
      pv = grant_id[1];
      if (ctl_if.wr_burst_data_req || ctl_if.rd_burst_data_valid ||
          ctl_if.rd_burst_finish || ctl_if.wr_burst_finish)
        chk("no_misroute",
            64'({o_wdreq[1-cur_m], o_rvalid[1-cur_m],
                 o_rfin[1-cur_m], o_wfin[1-cur_m]}), 64'(0));
    end
  end

  // one master transaction; called at a negedge
  task automatic master_txn(input int m, input bit dw, input bit dr,
                            input int wl, input int rl,
                            input logic [AW-1:0] wa,
                            input logic [AW-1:0] ra);
    int budget;
    if (dw) begin
      wlen[m] = LW'(wl);
      waddr[m] = wa;
      wbase[m] = wcnt[m];
      exp_q[m].push_back('{wr: 1'b1, len: wl, addr: wa, stamp: cyc});
      rq_wr[m] = 1'b1;
    end
    if (dr) begin
      rlen[m] = LW'(rl);
      raddr[m] = ra;
      rbase[m] = rcnt[m];
      exp_q[m].push_back('{wr: 1'b0, len: rl, addr: ra, stamp: cyc});
      rq_rd[m] = 1'b1;
    end
    budget = 0;
    while ((rq_wr[m] || rq_rd[m]) && budget < 4000) begin
      @(negedge clk);
      budget++;
      if (o_wfin[m] && rq_wr[m]) begin
        chk($sformatf("m%0d_wr_words", m), 64'(wcnt[m] - wbase[m]),
            64'(wl));
        rq_wr[m] = 1'b0;
      end
      if (o_rfin[m] && rq_rd[m]) begin
        chk($sformatf("m%0d_rd_words", m), 64'(rcnt[m] - rbase[m]),
            64'(rl));
        rq_rd[m] = 1'b0;
      end
    end
    if (rq_wr[m] || rq_rd[m]) begin
      n_chk++;
      $display("FAIL m%0d_timeout: got no finish required finish", m);
      rq_wr[m] = 1'b0;
      rq_rd[m] = 1'b0;
    end
  endtask

  task automatic master_rand(input int m, input int n);
    bit dw, dr;
    int sel;
    for (int k = 0; k < n; k++) begin
      sel = $urandom_range(0, 2);
      dw = (sel != 1);
      dr = (sel != 0);
      master_txn(m, dw, dr,
                 ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12),
                 ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12),
                 AW'($urandom), AW'($urandom));
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got no end required end");
    $fatal(1);
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      rq_rd[m] = 1'b0;
      rq_wr[m] = 1'b0;
      rlen[m]  = '0;
      wlen[m]  = '0;
      raddr[m] = '0;
      waddr[m] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_grant", 64'(grant_id), 64'(0));
    chk("rst_reqs", 64'({ctl_if.rd_burst_req, ctl_if.wr_burst_req}),
        64'(0));
    chk("rst_len", 64'({ctl_if.rd_burst_len, ctl_if.wr_burst_len}),
        64'(0));
    chk("rst_addr", 64'({ctl_if.rd_burst_addr, ctl_if.wr_burst_addr}),
        64'(0));
    chk("rst_wdata", 64'(ctl_if.wr_burst_data), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // simultaneous reads from reset, then continuous alternation
    fork
      master_txn(0, 1'b0, 1'b1, 0, 8, '0, 24'h001000);
      master_txn(1, 1'b0, 1'b1, 0, 8, '0, 24'h002000);
    join
    @(negedge clk);
    fork
      for (int k = 0; k < 3; k++) begin
        master_txn(0, 1'b0, 1'b1, 0, 3, '0, AW'(24'h003000 + k));
        @(negedge clk);
      end
      for (int k = 0; k < 3; k++) begin
        master_txn(1, 1'b0, 1'b1, 0, 3, '0, AW'(24'h004000 + k));
        @(negedge clk);
      end
    join
    repeat (2) @(negedge clk);

    // long write on m0, then m1 write+read, then zero-length write
    master_txn(0, 1'b1, 1'b0, 128, 0, 24'h000100, '0);
    repeat (2) @(negedge clk);
    master_txn(1, 1'b1, 1'b1, 4, 4, 24'h00abc0, 24'h00def0);
    repeat (2) @(negedge clk);
    master_txn(0, 1'b1, 1'b0, 0, 0, 24'h000200, '0);
    repeat (2) @(negedge clk);

    // reset in the middle of a read burst
    rlen[0]  = LW'(20);
    raddr[0] = 24'h005000;
    rbase[0] = rcnt[0];
    exp_q[0].push_back('{wr: 1'b0, len: 20, addr: 24'h005000,
                         stamp: cyc});
    rq_rd[0] = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_burst_req", 64'(ctl_if.rd_burst_req), 64'(1));
    rst = 1'b1;
    #1;
    chk("rst_mid_req", 64'(ctl_if.rd_burst_req), 64'(0));
    chk("rst_mid_grant", 64'(grant_id), 64'(0));
    rq_rd[0] = 1'b0;
    exp_q[0].delete();
    exp_q[1].delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    master_txn(0, 1'b0, 1'b1, 0, 5, '0, 24'h006000);
    repeat (2) @(negedge clk);

    // random concurrent traffic
    fork
      master_rand(0, 25);
      master_rand(1, 25);
    join
    repeat (4) @(negedge clk);
    chk("drain_q0", 64'(exp_q[0].size()), 64'(0));
    chk("drain_q1", 64'(exp_q[1].size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_burst_arbiter.md
MEM_BURST_ARBITER -- requirements
Module: mem_burst_arbiter

Interface
- REQ-001 SHALL have parameter MEM_DATA_BITS, default 16, user data width.
- REQ-002 SHALL have parameter ADDR_BITS, default 24, burst address width.
- REQ-003 SHALL have parameter BUSRT_BITS, default 10, burst length width (words).
- REQ-004 SHALL have port clk, input, 1, single clock (SDRAM controller clock); all logic on rising edge.
- REQ-005 SHALL have port rst, input, 1, reset, asynchronous and active-high.
- REQ-006 SHALL have ports m0_/m1_rd_burst_req, input, 1 each, master read request, held until that master's rd_burst_finish.
- REQ-007 SHALL have ports m0_/m1_wr_burst_req, input, 1 each, master write request, held until that master's wr_burst_finish.
- REQ-008 SHALL have ports m0_/m1_rd_burst_len and m0_/m1_wr_burst_len, input, BUSRT_BITS each, burst lengths.
- REQ-009 SHALL have ports m0_/m1_rd_burst_addr and m0_/m1_wr_burst_addr, input, ADDR_BITS each, burst base addresses.
- REQ-010 SHALL have ports m0_/m1_wr_burst_data, input, MEM_DATA_BITS each, master write data.
- REQ-011 SHALL have ports m0_/m1_wr_burst_data_req, m0_/m1_rd_burst_data_valid, m0_/m1_rd_burst_finish, m0_/m1_wr_burst_finish, output, 1 each, routed status.
- REQ-012 SHALL have ports m0_/m1_rd_burst_data, output, MEM_DATA_BITS each, read data.
- REQ-013 SHALL have controller-side ports rd_burst_req, wr_burst_req (out, 1), rd_/wr_burst_len (out, BUSRT_BITS), rd_/wr_burst_addr (out, ADDR_BITS), wr_burst_data (out, MEM_DATA_BITS).
- REQ-014 SHALL have controller-side inputs wr_burst_data_req, rd_burst_data_valid, rd_burst_finish, wr_burst_finish (1 each) and rd_burst_data (MEM_DATA_BITS).
- REQ-015 SHALL have port grant_id, output, 2, {valid, master} of the burst in progress.

Function
- REQ-016 SHALL implement FSM states IDLE, RD, WR, DONE.
- REQ-017 In IDLE, SHALL select a master: round-robin, the master not served last wins if requesting, else the other.
- REQ-018 Within the selected master, a write request SHALL win over a simultaneous read request.
- REQ-019 On grant, SHALL register len/addr and assert the matching controller req on the next cycle (1-cycle latency), entering RD or WR.
- REQ-020 Controller len/addr/req SHALL be registered and stable for the whole burst; master inputs changing mid-burst SHALL be ignored.
- REQ-021 Controller req SHALL deassert in the cycle after the controller finish pulse; the FSM SHALL enter DONE, then IDLE (one idle turnaround cycle).
- REQ-022 wr_burst_data SHALL be a combinational mux of the granted master's data; wr_burst_data_req, rd_burst_data_valid and finish pulses SHALL route combinationally to the granted master only; the non-granted master sees 0.
- REQ-023 rd_burst_data SHALL be broadcast to both masters; validity is indicated only by the routed valid.
- REQ-024 A granted request with len 0 SHALL NOT reach the controller; the arbiter SHALL pulse that master's finish for 1 cycle and go to DONE.
- REQ-025 A request deasserted before grant SHALL be dropped without side effects.
- REQ-026 The last-served master bit SHALL update at grant.

Reset
- REQ-027 On rst, SHALL enter IDLE immediately, including mid-burst.
- REQ-028 On rst, all controller outputs and grant_id SHALL be 0, and the last-served bit SHALL be 1 so that m0 wins the first tie.

Configuration
- REQ-029 With macro ARB_FIXED_PRIO_EN defined, m0 SHALL always win over m1 and the last-served bit SHALL be removed.
- REQ-030 Without ARB_FIXED_PRIO_EN, round-robin per REQ-017 SHALL apply.

Verification
- REQ-031 m0 wr len 128 addr 0x000100 alone -> wr_burst_req high 1 cycle later, len 128, addr 0x000100; 128 data_req routed to m0 only; m0_wr_burst_finish 1 pulse; grant_id 2'b10.
- REQ-032 m0 and m1 rd requests together from reset -> m0 served first, then m1 after DONE; repeated continuous requests alternate m0, m1, m0.
- REQ-033 m1 rd and wr together (len 4 each) -> write burst first, then read; m1_rd_burst_data_valid pulses 4 times, m0 valid stays 0.
- REQ-034 m0 wr len 0 -> no controller req; m0_wr_burst_finish pulses once within 2 cycles of request.
- REQ-035 rst asserted mid read burst -> rd_burst_req and grant_id 0 in the same cycle; FSM back in IDLE; next request served normally.
- REQ-036 With ARB_FIXED_PRIO_EN defined and both masters continuously requesting -> m0 served every time.
